// File: rtl/quad_encoder_bank.sv
// quad_encoder_bank: N-channel quadrature encoder front end (sync, glitch filter, decode, snapshot).
// Define INDEX_EN to add per-channel index (Z) inputs that zero the count and set index_seen.
module quad_encoder_bank #(
  parameter int CHANNELS     = 2,
  parameter int COUNT_W      = 32,
  parameter int FILTER_DEPTH = 3
) (
  input  logic                         CLK,
  input  logic                         resetn,
  input  logic [CHANNELS-1:0]          ENC_A,
  input  logic [CHANNELS-1:0]          ENC_B,
`ifdef INDEX_EN
  input  logic [CHANNELS-1:0]          ENC_Z,
  output logic [CHANNELS-1:0]          index_seen,
`endif
  input  logic [CHANNELS-1:0]          enable,
  input  logic [CHANNELS-1:0]          clear,
  input  logic                         latch,
  output logic [CHANNELS*COUNT_W-1:0]  count,
  output logic [CHANNELS*COUNT_W-1:0]  snap,
  output logic                         snap_valid,
  output logic [CHANNELS-1:0]          dir,
  output logic [CHANNELS-1:0]          err
);

`ifdef INDEX_EN
  localparam int NP = 3;
`else
  localparam int NP = 2;
`endif
  localparam int PW = $clog2(FILTER_DEPTH + 3);
  localparam logic [PW-1:0] PrimeAt  = PW'(FILTER_DEPTH + 1);
  localparam logic [PW-1:0] PrimeEnd = PW'(FILTER_DEPTH + 2);

  logic [CHANNELS-1:0][NP-1:0]                   raw;
  logic [CHANNELS-1:0][NP-1:0]                   sync1_q, sync2_q;
  logic [CHANNELS-1:0][NP-1:0][FILTER_DEPTH-1:0] hist_q, hist_d;
  logic [CHANNELS-1:0][NP-1:0]                   filt_q, filt_d;
  logic [PW-1:0]                                 primeCnt_q, primeCnt_d;
  logic                                          primeNow;
  logic [CHANNELS-1:0]                           primed_q, primed_d;
  logic [CHANNELS-1:0][COUNT_W-1:0]              count_q, count_d;
  logic [CHANNELS-1:0][COUNT_W-1:0]              snap_q, snap_d;
  logic                                          snapValid_q, snapValid_d;
  logic [CHANNELS-1:0]                           dir_q, dir_d;
  logic [CHANNELS-1:0]                           err_q, err_d;
`ifdef INDEX_EN
  logic [CHANNELS-1:0]                           index_q, index_d;
`endif

  always_comb begin
    raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      raw[c][0] = ENC_A[c];
      raw[c][1] = ENC_B[c];
`ifdef INDEX_EN
      raw[c][2] = ENC_Z[c];
`endif
    end
  end

  // Startup counter: the filtered levels are seeded exactly once, when the window first holds real samples.
  always_comb begin
    primeNow   = (primeCnt_q == PrimeAt);
    primeCnt_d = (primeCnt_q == PrimeEnd) ? primeCnt_q : primeCnt_q + PW'(1);
    primed_d   = primeNow ? '1 : primed_q;
  end

  always_comb begin
    hist_d = hist_q;
    filt_d = filt_q;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int p = 0; p < NP; p++) begin
        hist_d[c][p][0] = sync2_q[c][p];
        for (int j = 1; j < FILTER_DEPTH; j++) begin
          hist_d[c][p][j] = hist_q[c][p][j-1];
        end
        if (!primed_q[c]) begin
          if (primeNow) begin
            filt_d[c][p] = sync2_q[c][p];
          end
        end else if (&hist_q[c][p]) begin
          filt_d[c][p] = 1'b1;
        end else if (~|hist_q[c][p]) begin
          filt_d[c][p] = 1'b0;
        end
      end
    end
  end

  // Gray position {B, A^B} turns the sequence 00->10->11->01 into 0,1,2,3 so a step is a +/-1 difference.
  always_comb begin
    logic [1:0] newIdx;
    logic [1:0] oldIdx;
    logic [1:0] delta;
    newIdx  = '0;
    oldIdx  = '0;
    delta   = '0;
    count_d = count_q;
    dir_d   = dir_q;
    err_d   = err_q;
`ifdef INDEX_EN
    index_d = index_q;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      newIdx = {filt_d[c][1], filt_d[c][0] ^ filt_d[c][1]};
      oldIdx = {filt_q[c][1], filt_q[c][0] ^ filt_q[c][1]};
      delta  = newIdx - oldIdx;
      if (primed_q[c] && enable[c]) begin
        case (delta)
          2'd1: begin
            count_d[c] = count_q[c] + COUNT_W'(1);
            dir_d[c]   = 1'b1;
          end
          2'd3: begin
            count_d[c] = count_q[c] - COUNT_W'(1);
            dir_d[c]   = 1'b0;
          end
          2'd2: err_d[c] = 1'b1;
          default: ;
        endcase
`ifdef INDEX_EN
        if (filt_d[c][2] && !filt_q[c][2]) begin
          count_d[c] = '0;
          dir_d[c]   = dir_q[c];
          index_d[c] = 1'b1;
        end
`endif
      end
      if (clear[c]) begin
        count_d[c] = '0;
        err_d[c]   = 1'b0;
        dir_d[c]   = dir_q[c];
`ifdef INDEX_EN
        index_d[c] = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    snap_d      = latch ? count_q : snap_q;
    snapValid_d = latch;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      hist_q      <= '0;
      filt_q      <= '0;
      primeCnt_q  <= '0;
      primed_q    <= '0;
      count_q     <= '0;
      snap_q      <= '0;
      snapValid_q <= 1'b0;
      dir_q       <= '0;
      err_q       <= '0;
`ifdef INDEX_EN
      index_q     <= '0;
`endif
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      hist_q      <= hist_d;
      filt_q      <= filt_d;
      primeCnt_q  <= primeCnt_d;
      primed_q    <= primed_d;
      count_q     <= count_d;
      snap_q      <= snap_d;
      snapValid_q <= snapValid_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
`ifdef INDEX_EN
      index_q     <= index_d;
`endif
    end
  end

  assign count      = count_q;
  assign snap       = snap_q;
  assign snap_valid = snapValid_q;
  assign dir        = dir_q;
  assign err        = err_q;
`ifdef INDEX_EN
  assign index_seen = index_q;
`endif

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Scoreboard bench for quad_encoder_bank: expected counts are queued as steps are driven and popped at the
// cycle the decoder must react. Index tests are compiled in only when INDEX_EN is defined.
module tb_quad_encoder_bank;
  localparam int CH = 2;
  localparam int CW = 8;
  localparam int FD = 3;

  logic             CLK = 1'b0;
  logic             resetn;
  logic [CH-1:0]    ENC_A, ENC_B, enable, clear;
  logic             latch;
  logic [CH*CW-1:0] count, snap;
  logic             snap_valid;
  logic [CH-1:0]    dir, err;
`ifdef INDEX_EN
  logic [CH-1:0]    ENC_Z, index_seen;
  logic             mIndex[CH];
`endif

  typedef struct {
    string         tag;
    int            ch;
    logic [CW-1:0] cnt;
    logic          e;
    logic          d;
  } exp_t;

  exp_t          sbQ[$];
  int            posIdx[CH];
  logic [CW-1:0] mCount[CH];
  logic          mErr[CH];
  logic          mDir[CH];
  int            total = 0;
  int            bad   = 0;

  quad_encoder_bank #(.CHANNELS(CH), .COUNT_W(CW), .FILTER_DEPTH(FD)) dut (
    .CLK(CLK),
    .resetn(resetn),
    .ENC_A(ENC_A),
    .ENC_B(ENC_B),
`ifdef INDEX_EN
    .ENC_Z(ENC_Z),
    .index_seen(index_seen),
`endif
    .enable(enable),
    .clear(clear),
    .latch(latch),
    .count(count),
    .snap(snap),
    .snap_valid(snap_valid),
    .dir(dir),
    .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input string tag, input int ch);
    exp_t e;
    e.tag = tag;
    e.ch  = ch;
    e.cnt = mCount[ch];
    e.e   = mErr[ch];
    e.d   = mDir[ch];
    sbQ.push_back(e);
  endtask

  task automatic popCheck();
    exp_t e;
    if (sbQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard underflow");
      return;
    end
    e = sbQ.pop_front();
    checkOutput({e.tag, ".count"}, 32'(count[e.ch*CW +: CW]), 32'(e.cnt));
    checkOutput({e.tag, ".err"}, 32'(err[e.ch]), 32'(e.e));
    checkOutput({e.tag, ".dir"}, 32'(dir[e.ch]), 32'(e.d));
  endtask

  // Gray table for {A,B}: 0=00, 1=10, 2=11, 3=01.
  task automatic driveIdx(input int ch);
    ENC_A[ch] = (posIdx[ch] == 1) || (posIdx[ch] == 2);
    ENC_B[ch] = (posIdx[ch] >= 2);
  endtask

  task automatic resetModel();
    for (int i = 0; i < CH; i++) begin
      mCount[i] = '0;
      mErr[i]   = 1'b0;
      mDir[i]   = 1'b0;
`ifdef INDEX_EN
      mIndex[i] = 1'b0;
`endif
    end
  endtask

  // kind: 1 forward, -1 reverse, 2 illegal double change.
  task automatic applyStimulus(input int ch, input int kind, input bit doLatch, input string tag);
    logic [CW-1:0] preCount[CH];
    @(negedge CLK);
    for (int i = 0; i < CH; i++) preCount[i] = mCount[i];
    pushExp({tag, ".pre"}, ch);
    if (kind == 1) begin
      posIdx[ch] = (posIdx[ch] + 1) % 4;
      if (enable[ch]) begin mCount[ch] = mCount[ch] + 8'd1; mDir[ch] = 1'b1; end
    end else if (kind == -1) begin
      posIdx[ch] = (posIdx[ch] + 3) % 4;
      if (enable[ch]) begin mCount[ch] = mCount[ch] - 8'd1; mDir[ch] = 1'b0; end
    end else begin
      posIdx[ch] = (posIdx[ch] + 2) % 4;
      if (enable[ch]) mErr[ch] = 1'b1;
    end
    driveIdx(ch);
    pushExp({tag, ".post"}, ch);
    repeat (FD + 2) @(negedge CLK);
    popCheck();
    if (doLatch) latch = 1'b1;
    @(negedge CLK);
    latch = 1'b0;
    popCheck();
    if (doLatch) begin
      checkOutput({tag, ".snapValid"}, 32'(snap_valid), 32'(1));
      for (int i = 0; i < CH; i++) checkOutput({tag, ".snap"}, 32'(snap[i*CW +: CW]), 32'(preCount[i]));
      @(negedge CLK);
      checkOutput({tag, ".snapValidLow"}, 32'(snap_valid), 32'(0));
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic pulseClear(input int ch);
    @(negedge CLK);
    clear[ch] = 1'b1;
    @(negedge CLK);
    clear[ch] = 1'b0;
    mCount[ch] = '0;
    mErr[ch]   = 1'b0;
`ifdef INDEX_EN
    mIndex[ch] = 1'b0;
`endif
  endtask

  initial begin
    resetn = 1'b0;
    ENC_A  = 2'b01;
    ENC_B  = 2'b01;
    enable = 2'b11;
    clear  = 2'b00;
    latch  = 1'b0;
`ifdef INDEX_EN
    ENC_Z  = 2'b00;
`endif
    posIdx[0] = 2;
    posIdx[1] = 0;
    resetModel();

    repeat (3) @(negedge CLK);
    checkOutput("rst.count", 32'(count), 32'(0));
    checkOutput("rst.snap", 32'(snap), 32'(0));
    checkOutput("rst.snapValid", 32'(snap_valid), 32'(0));
    checkOutput("rst.dir", 32'(dir), 32'(0));
    checkOutput("rst.err", 32'(err), 32'(0));

    // Priming with ch0 resting at 11 must not register a step.
    resetn = 1'b1;
    repeat (FD + 3) @(negedge CLK);
    checkOutput("prime.count", 32'(count), 32'(0));
    checkOutput("prime.err", 32'(err), 32'(0));
    repeat (5) @(negedge CLK);

    for (int s = 0; s < 8; s++) applyStimulus(0, 1, 1'b0, "fwd");
    for (int s = 0; s < 3; s++) applyStimulus(0, -1, 1'b0, "rev");

    @(negedge CLK);
    ENC_A[0] = ~ENC_A[0];
    repeat (2) @(negedge CLK);
    ENC_A[0] = ~ENC_A[0];
    repeat (10) @(negedge CLK);
    checkOutput("glitch.count0", 32'(count[0 +: CW]), 32'(mCount[0]));
    checkOutput("glitch.err0", 32'(err[0]), 32'(0));

    applyStimulus(1, 1, 1'b0, "ch1fwd");
    applyStimulus(1, 1, 1'b0, "ch1fwd");
    applyStimulus(1, 2, 1'b0, "ch1jump");
    checkOutput("jump.count0", 32'(count[0 +: CW]), 32'(mCount[0]));
    checkOutput("jump.err0", 32'(err[0]), 32'(0));
    pulseClear(1);
    checkOutput("clr.count1", 32'(count[CW +: CW]), 32'(mCount[1]));
    checkOutput("clr.err1", 32'(err[1]), 32'(0));
    checkOutput("clr.dir1", 32'(dir[1]), 32'(mDir[1]));

    // Disabled channel keeps tracking pins; re-enabling must not count the missed step.
    enable[0] = 1'b0;
    applyStimulus(0, 1, 1'b0, "dis");
    enable[0] = 1'b1;
    repeat (10) @(negedge CLK);
    checkOutput("reen.count0", 32'(count[0 +: CW]), 32'(mCount[0]));
    applyStimulus(0, 1, 1'b0, "reen");

    pulseClear(0);
    applyStimulus(0, -1, 1'b0, "wrap");
    applyStimulus(0, 1, 1'b1, "latchStep");

    @(negedge CLK);
    latch = 1'b1;
    @(negedge CLK);
    checkOutput("b2b.valid1", 32'(snap_valid), 32'(1));
    @(negedge CLK);
    checkOutput("b2b.valid2", 32'(snap_valid), 32'(1));
    latch = 1'b0;
    @(negedge CLK);
    checkOutput("b2b.valid3", 32'(snap_valid), 32'(0));
    checkOutput("b2b.snap", 32'(snap), 32'({mCount[1], mCount[0]}));

    applyStimulus(0, 1, 1'b0, "preRst");
    #2 resetn = 1'b0;
    #1;
    checkOutput("midRst.count", 32'(count), 32'(0));
    checkOutput("midRst.dir", 32'(dir), 32'(0));
    resetModel();
    @(negedge CLK);
    resetn = 1'b1;
    repeat (FD + 8) @(negedge CLK);
    checkOutput("reprime.count", 32'(count), 32'(0));
    applyStimulus(0, 1, 1'b0, "afterRst");

`ifdef INDEX_EN
    while (mCount[0] != 8'd37) applyStimulus(0, 1, 1'b0, "toIdx");
    @(negedge CLK);
    posIdx[0] = (posIdx[0] + 1) % 4;
    driveIdx(0);
    ENC_Z[0]  = 1'b1;
    mCount[0] = '0;
    mIndex[0] = 1'b1;
    repeat (FD + 3) @(negedge CLK);
    ENC_Z[0] = 1'b0;
    repeat (8) @(negedge CLK);
    checkOutput("idx.count0", 32'(count[0 +: CW]), 32'(mCount[0]));
    checkOutput("idx.seen0", 32'(index_seen[0]), 32'(mIndex[0]));
    checkOutput("idx.dir0", 32'(dir[0]), 32'(mDir[0]));
    pulseClear(0);
    checkOutput("idxClr.seen0", 32'(index_seen[0]), 32'(0));
    applyStimulus(0, 1, 1'b0, "idxStep");
    enable[0] = 1'b0;
    @(negedge CLK);
    ENC_Z[0] = 1'b1;
    repeat (FD + 3) @(negedge CLK);
    ENC_Z[0] = 1'b0;
    repeat (8) @(negedge CLK);
    enable[0] = 1'b1;
    checkOutput("idxDis.count0", 32'(count[0 +: CW]), 32'(mCount[0]));
    checkOutput("idxDis.seen0", 32'(index_seen[0]), 32'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
